// File: rtl/cart_map_pkg.sv
// rtl/cart_map_pkg.sv - shared types and constants for the cartridge mapper selector
package cart_map_pkg;

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      LOCKED = 2'd1,
      FAULT  = 2'd2
   } map_state_t;

   localparam int DEFAULT_CH = 0;
   localparam int CH_DSP     = 0;
   localparam int CH_CX4     = 1;
   localparam int CH_SDD1    = 2;
   localparam int CH_GSU     = 3;
   localparam int CH_SA1     = 4;
   localparam int CH_MSU     = 5;

   function automatic int sel_width(input int num_maps);
      return (num_maps > 1) ? $clog2(num_maps) : 1;
   endfunction

endpackage

// File: rtl/cart_map_mux_if.sv
// rtl/cart_map_mux_if.sv - core-side and mapper-side bus bundle of the mapper selector
interface cart_map_mux_if
   import cart_map_pkg::*;
#(
   parameter int NUM_MAPS = 6,
   parameter int ROM_AW   = 24,
   parameter int BSRAM_AW = 20
);
   localparam int SEL_W = sel_width(NUM_MAPS);

   logic [NUM_MAPS-2:0]          map_active;
   logic [NUM_MAPS-1:0]          ch_has_mem;
   logic [NUM_MAPS*8-1:0]        ch_do;
   logic [NUM_MAPS-1:0]          ch_irq_n;
   logic [NUM_MAPS*ROM_AW-1:0]   ch_rom_addr;
   logic [NUM_MAPS-1:0]          ch_rom_ce_n;
   logic [NUM_MAPS-1:0]          ch_rom_oe_n;
   logic [NUM_MAPS-1:0]          ch_rom_word;
   logic [NUM_MAPS*BSRAM_AW-1:0] ch_bsram_addr;
   logic [NUM_MAPS*8-1:0]        ch_bsram_d;
   logic [NUM_MAPS-1:0]          ch_bsram_ce_n;
   logic [NUM_MAPS-1:0]          ch_bsram_oe_n;
   logic [NUM_MAPS-1:0]          ch_bsram_we_n;

   logic [7:0]                   di;
   logic                         irq_n;
   logic [ROM_AW-1:0]            rom_addr;
   logic                         rom_ce_n;
   logic                         rom_oe_n;
   logic                         rom_word;
   logic [BSRAM_AW-1:0]          bsram_addr;
   logic [7:0]                   bsram_d;
   logic                         bsram_ce_n;
   logic                         bsram_oe_n;
   logic                         bsram_we_n;
   logic [SEL_W-1:0]             map_sel;
   logic                         map_locked;
   logic                         map_fault;

   modport master (
      output map_active, ch_has_mem, ch_do, ch_irq_n, ch_rom_addr, ch_rom_ce_n, ch_rom_oe_n,
             ch_rom_word, ch_bsram_addr, ch_bsram_d, ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n,
      input  di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word, bsram_addr, bsram_d,
             bsram_ce_n, bsram_oe_n, bsram_we_n, map_sel, map_locked, map_fault
   );

   modport slave (
      input  map_active, ch_has_mem, ch_do, ch_irq_n, ch_rom_addr, ch_rom_ce_n, ch_rom_oe_n,
             ch_rom_word, ch_bsram_addr, ch_bsram_d, ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n,
      output di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word, bsram_addr, bsram_d,
             bsram_ce_n, bsram_oe_n, bsram_we_n, map_sel, map_locked, map_fault
   );

endinterface

// File: rtl/cart_map_sel_fsm.sv
// rtl/cart_map_sel_fsm.sv - settle/lock qualification of the one-hot mapper request
module cart_map_sel_fsm
   import cart_map_pkg::*;
#(
   parameter int NUM_MAPS   = 6,
   parameter int SETTLE_CYC = 4,
   parameter int SEL_W      = sel_width(NUM_MAPS)
) (
   input  logic                mclk,
   input  logic                rst,
   input  logic [NUM_MAPS-2:0] map_active,
   output map_state_t          state,
   output logic [SEL_W-1:0]    map_sel,
   output logic                map_locked,
   output logic                map_fault
);
   localparam int AW    = NUM_MAPS - 1;
   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYC - 1);

   map_state_t       state_n;
   logic [AW-1:0]    prev;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [SEL_W-1:0] sel_n;
   logic [SEL_W-1:0] hot_sel;
   logic             stable;
   logic             multi_hot;

   always_ff @(posedge mclk) begin
      if (rst) begin
         state   <= SETTLE;
         cnt     <= '0;
         map_sel <= '0;
         prev    <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         map_sel <= sel_n;
         prev    <= map_active;
      end
   end

   always_comb begin
      stable    = (map_active == prev);
      // x & (x-1) clears the lowest set bit; anything left means two or more requests
      multi_hot = |(map_active & (map_active - AW'(1)));
      hot_sel   = '0;
      for (int i = 0; i < AW; i++) begin
         if (map_active[i]) hot_sel = SEL_W'(i + 1);
      end

      state_n = state;
      cnt_n   = cnt;
      sel_n   = map_sel;
      case (state)
         SETTLE: begin
            if (!stable) begin
               cnt_n = '0;
            end else if (cnt == CNT_MAX) begin
               cnt_n = '0;
               if (multi_hot) begin
                  state_n = FAULT;
                  sel_n   = SEL_W'(DEFAULT_CH);
               end else begin
                  state_n = LOCKED;
                  sel_n   = hot_sel;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         LOCKED, FAULT: begin
            if (!stable) begin
               state_n = SETTLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = SETTLE;
            cnt_n   = '0;
         end
      endcase

      map_locked = (state == LOCKED);
      map_fault  = (state == FAULT);
   end

endmodule

// File: rtl/cart_map_mux.sv
// rtl/cart_map_mux.sv - N-way cartridge mapper output mux; CART_IRQ_SHARE_EN ANDs all channel IRQs
module cart_map_mux
   import cart_map_pkg::*;
#(
   parameter int NUM_MAPS   = 6,
   parameter int ROM_AW     = 24,
   parameter int BSRAM_AW   = 20,
   parameter int SETTLE_CYC = 4
) (
   input logic           mclk,
   input logic           rst,
   cart_map_mux_if.slave bus
);
   localparam int SEL_W = sel_width(NUM_MAPS);

   map_state_t       state;
   logic [SEL_W-1:0] sel;
   logic             locked;
   logic             fault;
   logic             active;
   int               d_ch;
   int               m_ch;

   cart_map_sel_fsm #(
      .NUM_MAPS   (NUM_MAPS),
      .SETTLE_CYC (SETTLE_CYC),
      .SEL_W      (SEL_W)
   ) u_sel_fsm (
      .mclk       (mclk),
      .rst        (rst),
      .map_active (bus.map_active),
      .state      (state),
      .map_sel    (sel),
      .map_locked (locked),
      .map_fault  (fault)
   );

   always_comb begin
      active = (state == LOCKED) || (state == FAULT);
      d_ch   = int'(sel);
      // memory-less mappers still need the default mapper's ROM/BSRAM behind them
      m_ch   = bus.ch_has_mem[sel] ? int'(sel) : DEFAULT_CH;

      bus.map_sel    = sel;
      bus.map_locked = locked;
      bus.map_fault  = fault;
      bus.di         = 8'h00;
      bus.irq_n      = 1'b1;
      bus.rom_addr   = '0;
      bus.rom_ce_n   = 1'b1;
      bus.rom_oe_n   = 1'b1;
      bus.rom_word   = 1'b0;
      bus.bsram_addr = '0;
      bus.bsram_d    = 8'h00;
      bus.bsram_ce_n = 1'b1;
      bus.bsram_oe_n = 1'b1;
      bus.bsram_we_n = 1'b1;

      if (active) begin
         bus.di         = bus.ch_do[d_ch*8 +: 8];
`ifdef CART_IRQ_SHARE_EN
         bus.irq_n      = &bus.ch_irq_n;
`else
         bus.irq_n      = bus.ch_irq_n[sel];
`endif
         bus.rom_addr   = bus.ch_rom_addr[m_ch*ROM_AW +: ROM_AW];
         bus.rom_ce_n   = bus.ch_rom_ce_n[m_ch];
         bus.rom_oe_n   = bus.ch_rom_oe_n[m_ch];
         bus.rom_word   = bus.ch_rom_word[m_ch];
         bus.bsram_addr = bus.ch_bsram_addr[m_ch*BSRAM_AW +: BSRAM_AW];
         bus.bsram_d    = bus.ch_bsram_d[m_ch*8 +: 8];
         bus.bsram_ce_n = bus.ch_bsram_ce_n[m_ch];
         bus.bsram_oe_n = bus.ch_bsram_oe_n[m_ch];
         bus.bsram_we_n = bus.ch_bsram_we_n[m_ch];
      end
   end

endmodule

// File: tb/tb_cart_map_mux.sv
// tb/tb_cart_map_mux.sv - randomized self-checking bench for cart_map_mux against a behavioural model
module tb_cart_map_mux;
   import cart_map_pkg::*;

   localparam int N   = 6;
   localparam int RAW = 24;
   localparam int BAW = 20;
   localparam int SC  = 4;

   logic mclk = 1'b0;
   logic rst  = 1'b1;
   always #5 mclk = ~mclk;

   cart_map_mux_if #(.NUM_MAPS(N), .ROM_AW(RAW), .BSRAM_AW(BAW)) bus();

   cart_map_mux #(.NUM_MAPS(N), .ROM_AW(RAW), .BSRAM_AW(BAW), .SETTLE_CYC(SC)) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // model: mode 0 = settling, 1 = locked, 2 = fault
   int         m_mode = 0;
   int         m_sel  = 0;
   int         m_run  = 0;
   logic [N-2:0] m_prev = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_step();
      logic [N-2:0] cur;
      int ones;
      cur = bus.map_active;
      if (rst) begin
         m_mode = 0; m_sel = 0; m_run = 0; m_prev = '0;
      end else begin
         if (m_mode == 0) begin
            m_run = (cur == m_prev) ? m_run + 1 : 0;
            if (m_run == SC) begin
               m_run = 0;
               ones  = $countones(cur);
               if (ones == 0) begin
                  m_mode = 1; m_sel = 0;
               end else if (ones == 1) begin
                  m_mode = 1;
                  for (int i = 0; i < N - 1; i++) if (cur[i]) m_sel = i + 1;
               end else begin
                  m_mode = 2; m_sel = 0;
               end
            end
         end else if (cur != m_prev) begin
            m_mode = 0; m_run = 0;
         end
         m_prev = cur;
      end
   endfunction

   always @(negedge mclk) begin
      if (chk_en) begin
         bit act;
         int mc;
         act = (m_mode != 0);
         mc  = bus.ch_has_mem[m_sel] ? m_sel : 0;
         chk("map_sel",    32'(bus.map_sel),    32'(m_sel));
         chk("map_locked", 32'(bus.map_locked), 32'(m_mode == 1));
         chk("map_fault",  32'(bus.map_fault),  32'(m_mode == 2));
         chk("di",         32'(bus.di),         act ? 32'(bus.ch_do[m_sel*8 +: 8]) : 32'h0);
`ifdef CART_IRQ_SHARE_EN
         chk("irq_n",      32'(bus.irq_n),      act ? 32'(&bus.ch_irq_n) : 32'h1);
`else
         chk("irq_n",      32'(bus.irq_n),      act ? 32'(bus.ch_irq_n[m_sel]) : 32'h1);
`endif
         chk("rom_addr",   32'(bus.rom_addr),   act ? 32'(bus.ch_rom_addr[mc*RAW +: RAW]) : 32'h0);
         chk("rom_ce_n",   32'(bus.rom_ce_n),   act ? 32'(bus.ch_rom_ce_n[mc]) : 32'h1);
         chk("rom_oe_n",   32'(bus.rom_oe_n),   act ? 32'(bus.ch_rom_oe_n[mc]) : 32'h1);
         chk("rom_word",   32'(bus.rom_word),   act ? 32'(bus.ch_rom_word[mc]) : 32'h0);
         chk("bsram_addr", 32'(bus.bsram_addr), act ? 32'(bus.ch_bsram_addr[mc*BAW +: BAW]) : 32'h0);
         chk("bsram_d",    32'(bus.bsram_d),    act ? 32'(bus.ch_bsram_d[mc*8 +: 8]) : 32'h0);
         chk("bsram_ce_n", 32'(bus.bsram_ce_n), act ? 32'(bus.ch_bsram_ce_n[mc]) : 32'h1);
         chk("bsram_oe_n", 32'(bus.bsram_oe_n), act ? 32'(bus.ch_bsram_oe_n[mc]) : 32'h1);
         chk("bsram_we_n", 32'(bus.bsram_we_n), act ? 32'(bus.ch_bsram_we_n[mc]) : 32'h1);
      end
   end

   task automatic cyc();
      @(posedge mclk);
      model_step();
      #1;
   endtask

   task automatic set_fixed();
      for (int i = 0; i < N; i++) begin
         bus.ch_do[i*8 +: 8]           = 8'(8'hA0 + i);
         bus.ch_rom_addr[i*RAW +: RAW] = 24'(24'h1000 * i + 24'h000AB0);
         bus.ch_bsram_addr[i*BAW +: BAW] = 20'(20'h100 * i + 20'h33);
         bus.ch_bsram_d[i*8 +: 8]      = 8'(8'h50 + i);
         bus.ch_rom_ce_n[i]   = i[0];
         bus.ch_rom_oe_n[i]   = 1'b0;
         bus.ch_rom_word[i]   = i[0];
         bus.ch_bsram_ce_n[i] = 1'b0;
         bus.ch_bsram_oe_n[i] = i[0];
         bus.ch_bsram_we_n[i] = ~i[0];
      end
      bus.ch_irq_n   = '1;
      bus.ch_has_mem = '1;
   endtask

   task automatic set_random();
      for (int i = 0; i < N; i++) begin
         bus.ch_do[i*8 +: 8]             = 8'($urandom);
         bus.ch_rom_addr[i*RAW +: RAW]   = RAW'($urandom);
         bus.ch_bsram_addr[i*BAW +: BAW] = BAW'($urandom);
         bus.ch_bsram_d[i*8 +: 8]        = 8'($urandom);
      end
      bus.ch_irq_n      = N'($urandom);
      bus.ch_rom_ce_n   = N'($urandom);
      bus.ch_rom_oe_n   = N'($urandom);
      bus.ch_rom_word   = N'($urandom);
      bus.ch_bsram_ce_n = N'($urandom);
      bus.ch_bsram_oe_n = N'($urandom);
      bus.ch_bsram_we_n = N'($urandom);
      bus.ch_has_mem    = N'($urandom) | N'(1);
   endtask

   initial begin
      bus.map_active = '0;
      set_fixed();

      // reset, then zero-hot request locks on channel 0
      rst = 1'b1;
      cyc();
      chk_en = 1'b1;
      cyc();
      rst = 1'b0;
      repeat (3) cyc();
      chk("t1_locked_early", 32'(bus.map_locked), 32'h0);
      chk("t1_idle_rom_ce_n", 32'(bus.rom_ce_n), 32'h1);
      cyc();
      chk("t1_locked", 32'(bus.map_locked), 32'h1);
      chk("t1_sel", 32'(bus.map_sel), 32'h0);
      chk("t1_rom_addr", 32'(bus.rom_addr), 32'h000AB0);

      // single request on bit 2 -> channel 3
      bus.map_active = 5'b00100;
      cyc();
      chk("t2_idle_di", 32'(bus.di), 32'h0);
      repeat (3) cyc();
      chk("t2_locked_early", 32'(bus.map_locked), 32'h0);
      cyc();
      chk("t2_sel", 32'(bus.map_sel), 32'h3);
      chk("t2_di", 32'(bus.di), 32'hA3);

      // memory-less channel 5 borrows channel 0 memory
      bus.map_active = 5'b10000;
      bus.ch_has_mem[5] = 1'b0;
      repeat (5) cyc();
      chk("t3_di", 32'(bus.di), 32'hA5);
      chk("t3_rom_ce_n", 32'(bus.rom_ce_n), 32'h0);
      chk("t3_rom_addr", 32'(bus.rom_addr), 32'h000AB0);
      chk("t3_bsram_d", 32'(bus.bsram_d), 32'h50);
      bus.ch_has_mem[5] = 1'b1;

      // multi-hot fault, then recovery
      bus.map_active = 5'b00110;
      repeat (5) cyc();
      chk("t4_fault", 32'(bus.map_fault), 32'h1);
      chk("t4_sel", 32'(bus.map_sel), 32'h0);
      chk("t4_di", 32'(bus.di), 32'hA0);
      bus.map_active = 5'b00010;
      repeat (5) cyc();
      chk("t4_fault_clr", 32'(bus.map_fault), 32'h0);
      chk("t4_sel2", 32'(bus.map_sel), 32'h2);

      // request toggling every 2 cycles never settles
      for (int k = 0; k < 10; k++) begin
         bus.map_active = k[0] ? 5'b01000 : 5'b00001;
         cyc();
         chk("t5_locked", 32'(bus.map_locked), 32'h0);
         cyc();
         chk("t5_rom_ce_n", 32'(bus.rom_ce_n), 32'h1);
      end

      // IRQ from a non-selected channel
      bus.map_active = 5'b00001;
      repeat (5) cyc();
      bus.ch_irq_n[2] = 1'b0;
      #1;
`ifdef CART_IRQ_SHARE_EN
      chk("t6_irq_n", 32'(bus.irq_n), 32'h0);
`else
      chk("t6_irq_n", 32'(bus.irq_n), 32'h1);
`endif
      // reset mid-settle restarts the count
      bus.map_active = 5'b01000;
      repeat (2) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      repeat (3) cyc();
      chk("t6_locked_early", 32'(bus.map_locked), 32'h0);
      repeat (2) cyc();
      chk("t6_locked", 32'(bus.map_locked), 32'h1);
      chk("t6_sel", 32'(bus.map_sel), 32'h4);
      bus.ch_irq_n = '1;

      // randomized run
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 3))
               0:       bus.map_active = '0;
               1, 2:    bus.map_active = (N-1)'(1) << $urandom_range(0, N - 2);
               default: bus.map_active = (N-1)'($urandom);
            endcase
         end
         set_random();
         rst = ($urandom_range(0, 199) == 0);
         cyc();
      end
      rst = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
